// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with Moore detect output,
// saturating match counter and sticky hit flag.
module seq_detect_param #(
    parameter int              LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = 4'b1011,
    parameter int              OVERLAP = 1,
    parameter int              CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             w,
    input  logic             w_valid,
    input  logic             count_clr,
    output logic             z,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FMAX = FW'(LEN);
    localparam logic [FW-1:0] FARM = FW'(LEN - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        FILL,
        ARMED,
        DET
    } state_t;

    state_t           state_q, state_d;
    logic [LEN-1:0]   hist_q, hist_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hit_q, hit_d;
    logic [LEN-1:0]   shifted;
    logic             match_now;

    assign shifted   = {hist_q[LEN-2:0], w};
    assign match_now = w_valid && (state_q != FILL)
                     && (shifted == PATTERN);

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            hist_q  <= '0;
            fcnt_q  <= '0;
            count_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fcnt_q  <= fcnt_d;
            count_q <= count_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        hist_d  = hist_q;
        fcnt_d  = fcnt_q;
        count_d = count_q;
        hit_d   = hit_q;
        state_d = FILL;

        if (w_valid) begin
            hist_d = shifted;
            if (fcnt_q != FMAX) begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // Non-overlapping mode forces a full fresh pattern after a hit
        if (match_now && (OVERLAP == 0)) begin
            hist_d = '0;
            fcnt_d = '0;
        end

        if (count_clr) begin
            count_d = '0;
            hit_d   = 1'b0;
        end

        if (match_now) begin
            hit_d = 1'b1;
            if (count_clr) begin
                count_d = CNT_W'(1);
            end else if (count_q != CMAX) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (match_now) begin
            state_d = DET;
        end else if (fcnt_d >= FARM) begin
            state_d = ARMED;
        end else begin
            state_d = FILL;
        end
    end

    assign z     = (state_q == DET);
    assign count = count_q;
    assign hit   = hit_q;

endmodule
